// File: rtl/ref_clock_divider_pkg.sv
// State type and configuration legality rule shared by the reference clock divider.
package ref_clock_divider_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } div_state_e;

    // A period needs at least one high cycle and at least one low cycle.
    function automatic logic cfg_is_legal(input int unsigned ratio, input int unsigned high);
        return (ratio >= 32'd2) && (high >= 32'd1) && (high < ratio);
    endfunction

endpackage

// File: rtl/ref_clock_divider.sv
// Programmable reference clock divider with a one-deep config slot applied on period boundaries.
// Latency: clock_out rises 1 cycle after div_en is sampled high; every output comes from a flop.
// Backpressure: cfg_ready drops while a legal config waits in the slot for the next boundary.
module ref_clock_divider
    import ref_clock_divider_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEFAULT_RATIO = 2,
    parameter int DEFAULT_HIGH  = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             div_en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_ratio,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_err,
    output logic             clock_out,
    output logic             period_start
);

    if (!cfg_is_legal($unsigned(DEFAULT_RATIO), $unsigned(DEFAULT_HIGH))) begin : g_bad_default
        $fatal(1, "ref_clock_divider: illegal DEFAULT_RATIO/DEFAULT_HIGH pair");
    end

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ratio_act_q, ratio_act_d;
    logic [WIDTH-1:0] high_act_q, high_act_d;
    logic             pend_vld_q, pend_vld_d;
    logic [WIDTH-1:0] pend_ratio_q, pend_ratio_d;
    logic [WIDTH-1:0] pend_high_q, pend_high_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             cfg_err_q, cfg_err_d;
    logic             clk_out_q, clk_out_d;
    logic             pstart_q, pstart_d;

    logic boundary;
    logic apply_pt;
    logic cfg_xfer;
    logic cfg_legal;

    assign boundary  = (state_q == ST_RUN) && (cnt_q == ratio_act_q - WIDTH'(1));
    assign apply_pt  = (state_q == ST_IDLE) || boundary;
    assign cfg_xfer  = cfg_valid && cfg_ready_q;
    assign cfg_legal = cfg_is_legal(32'(cfg_ratio), 32'(cfg_high));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ratio_act_d  = ratio_act_q;
        high_act_d   = high_act_q;
        pend_vld_d   = pend_vld_q;
        pend_ratio_d = pend_ratio_q;
        pend_high_d  = pend_high_q;
        cfg_err_d    = cfg_xfer && !cfg_legal;
        clk_out_d    = 1'b0;
        pstart_d     = 1'b0;

        // A transfer is only possible with an empty slot, so bypass and drain never collide.
        if (cfg_xfer && cfg_legal) begin
            if (apply_pt) begin
                ratio_act_d = cfg_ratio;
                high_act_d  = cfg_high;
            end else begin
                pend_vld_d   = 1'b1;
                pend_ratio_d = cfg_ratio;
                pend_high_d  = cfg_high;
            end
        end else if (pend_vld_q && apply_pt) begin
            ratio_act_d = pend_ratio_q;
            high_act_d  = pend_high_q;
            pend_vld_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (div_en) begin
                    state_d   = ST_RUN;
                    clk_out_d = 1'b1;
                    pstart_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (boundary) begin
                    cnt_d = '0;
                    if (div_en) begin
                        clk_out_d = 1'b1;
                        pstart_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d     = cnt_q + WIDTH'(1);
                    clk_out_d = (cnt_d < high_act_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        cfg_ready_d = !pend_vld_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ratio_act_q  <= WIDTH'(DEFAULT_RATIO);
            high_act_q   <= WIDTH'(DEFAULT_HIGH);
            pend_vld_q   <= 1'b0;
            pend_ratio_q <= '0;
            pend_high_q  <= '0;
            cfg_ready_q  <= 1'b1;
            cfg_err_q    <= 1'b0;
            clk_out_q    <= 1'b0;
            pstart_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ratio_act_q  <= ratio_act_d;
            high_act_q   <= high_act_d;
            pend_vld_q   <= pend_vld_d;
            pend_ratio_q <= pend_ratio_d;
            pend_high_q  <= pend_high_d;
            cfg_ready_q  <= cfg_ready_d;
            cfg_err_q    <= cfg_err_d;
            clk_out_q    <= clk_out_d;
            pstart_q     <= pstart_d;
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign cfg_err      = cfg_err_q;
    assign clock_out    = clk_out_q;
    assign period_start = pstart_q;

endmodule

// File: tb/tb_ref_clock_divider.sv
// Self-checking bench: period-position reference model plus directed literal scenarios and random traffic.
module tb_ref_clock_divider;

    localparam int W     = 8;
    localparam int DEF_R = 2;
    localparam int DEF_H = 1;

    logic         clock        = 1'b0;
    logic         reset_n      = 1'b0;
    logic         div_en       = 1'b0;
    logic         cfg_valid    = 1'b0;
    logic [W-1:0] cfg_ratio    = '0;
    logic [W-1:0] cfg_high     = '0;
    logic         cfg_ready;
    logic         cfg_err;
    logic         clock_out;
    logic         period_start;

    int total = 0;
    int bad   = 0;

    ref_clock_divider #(
        .WIDTH        (W),
        .DEFAULT_RATIO(DEF_R),
        .DEFAULT_HIGH (DEF_H)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .div_en      (div_en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ratio   (cfg_ratio),
        .cfg_high    (cfg_high),
        .cfg_err     (cfg_err),
        .clock_out   (clock_out),
        .period_start(period_start)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position inside the current output period and the active/pending configs.
    int m_ratio = DEF_R, m_high = DEF_H, m_pos = 0, m_pr = 0, m_ph = 0;
    bit m_run = 1'b0, m_pend = 1'b0, m_err = 1'b0;
    bit m_free, m_took, m_ok;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_run   = 1'b0;
            m_pos   = 0;
            m_pend  = 1'b0;
            m_err   = 1'b0;
            m_ratio = DEF_R;
            m_high  = DEF_H;
        end else begin
            m_free = !m_run || (m_pos == m_ratio - 1);
            m_took = cfg_valid && !m_pend;
            m_ok   = (int'(cfg_ratio) >= 2) && (int'(cfg_high) >= 1) && (cfg_high < cfg_ratio);
            m_err  = m_took && !m_ok;
            if (m_took && m_ok && m_free) begin
                m_ratio = int'(cfg_ratio);
                m_high  = int'(cfg_high);
            end else if (m_took && m_ok) begin
                m_pend = 1'b1;
                m_pr   = int'(cfg_ratio);
                m_ph   = int'(cfg_high);
            end else if (m_pend && m_free) begin
                m_ratio = m_pr;
                m_high  = m_ph;
                m_pend  = 1'b0;
            end
            if (m_free) begin
                m_run = div_en;
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    end

    always @(negedge clock) begin
        check("clock_out",    32'(clock_out),    32'(m_run && (m_pos < m_high)));
        check("period_start", 32'(period_start), 32'(m_run && (m_pos == 0)));
        check("cfg_ready",    32'(cfg_ready),    32'(!m_pend));
        check("cfg_err",      32'(cfg_err),      32'(m_err));
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_ps();
        int n = 0;
        while (period_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL wait_period_start: no period_start within 20 cycles");
        end
    endtask

    task automatic reset_mid();
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_async_clock_out", 32'(clock_out), 32'd0);
        check("rst_async_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_async_pstart",    32'(period_start), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    logic [5:0] seq;
    logic [3:0] seq4;
    int         cnt;

    initial begin
        tick();
        check("reset_clock_out", 32'(clock_out), 32'd0);
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        check("reset_cfg_err",   32'(cfg_err),   32'd0);
        reset_n = 1'b1;
        tick();
        check("idle_clock_out", 32'(clock_out), 32'd0);

        // Defaults 2/1: alternating output, period_start every other cycle.
        div_en = 1'b1;
        seq4 = '0;
        cnt  = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seq4 = {seq4[2:0], clock_out};
            cnt += int'(period_start);
        end
        check("default_pattern", 32'(seq4), 32'b1010);
        check("default_pstarts", 32'(cnt),  32'd2);

        // 4/1 accepted mid-period: current period finishes, then 1,0,0,0.
        wait_ps();
        cfg_valid = 1'b1; cfg_ratio = 8'd4; cfg_high = 8'd1;
        tick();
        cfg_valid = 1'b0;
        check("mid_cfg_ready_busy", 32'(cfg_ready), 32'd0);
        seq = {5'b0, clock_out};
        tick();
        check("mid_cfg_ready_drained", 32'(cfg_ready), 32'd1);
        seq = {seq[4:0], clock_out};
        for (int i = 0; i < 4; i++) begin
            tick();
            seq = {seq[4:0], clock_out};
        end
        check("ratio4_pattern", 32'(seq), 32'b010001);

        // Two illegal configs: one error pulse each, active config untouched.
        cfg_valid = 1'b1; cfg_ratio = 8'd5; cfg_high = 8'd5;
        tick();
        check("err_high_eq_ratio", 32'(cfg_err), 32'd1);
        cfg_ratio = 8'd0; cfg_high = 8'd0;
        tick();
        check("err_ratio_zero", 32'(cfg_err), 32'd1);
        cfg_valid = 1'b0;
        tick();
        check("err_cleared", 32'(cfg_err), 32'd0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cnt += int'(period_start);
        end
        check("ratio4_kept_pstarts", 32'(cnt), 32'd2);

        // Second config held while the slot is full; it lands only after the slot drains.
        wait_ps();
        cfg_valid = 1'b1; cfg_ratio = 8'd3; cfg_high = 8'd2;
        tick();
        cfg_ratio = 8'd6; cfg_high = 8'd3;
        cnt = 0;
        while (cfg_ready !== 1'b1 && cnt < 20) begin
            cnt++;
            tick();
        end
        check("busy_cycles", 32'(cnt), 32'd3);
        tick();
        cfg_valid = 1'b0;
        wait_ps();
        seq = {5'b0, clock_out};
        for (int i = 0; i < 5; i++) begin
            tick();
            seq = {seq[4:0], clock_out};
        end
        check("ratio6_pattern", 32'(seq), 32'b111000);

        // div_en drops at cnt=1 of a 6-cycle period: period completes, then idle.
        tick();
        tick();
        div_en = 1'b0;
        seq = '0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seq = {seq[4:0], clock_out};
            cnt += int'(period_start);
        end
        check("disable_pattern", 32'(seq), 32'b100000);
        check("disable_pstarts", 32'(cnt), 32'd0);
        div_en = 1'b1;
        tick();
        check("enable_latency_clk", 32'(clock_out),    32'd1);
        check("enable_latency_ps",  32'(period_start), 32'd1);

        // Reset at cnt=2 while high; afterwards defaults 2/1 again.
        tick();
        tick();
        check("pre_reset_high", 32'(clock_out), 32'd1);
        reset_mid();
        seq4 = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seq4 = {seq4[2:0], clock_out};
        end
        check("post_reset_pattern", 32'(seq4), 32'b1010);

        // Random traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 11) == 0) div_en = ~div_en;
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ratio = 8'($urandom_range(0, 9));
            cfg_high  = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 399) == 0) begin
                reset_mid();
            end else begin
                tick();
            end
        end
        cfg_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
